// File: rtl/selu_act_arbiter.sv
// selu_act_arbiter: round-robin sharing of one fixed-latency activation unit
// between NUM_REQ channels. Each issued beat carries a channel tag down a
// LAT-deep pipeline so the result can be routed back to its source channel.
// Results with no matching tag, and tags with no result, raise a sticky err.
module selu_act_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int LAT       = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      act_in_valid,
  output logic [DATA_W-1:0]         act_in_data,
  input  logic                      act_out_valid,
  input  logic [DATA_W-1:0]         act_out_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      err
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int GCW = $clog2(LAT + 2);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Arbiter state; r_owner doubles as the "last owner" for the circular search.
  logic [0:0]        r_state;
  logic [IDW-1:0]    r_owner;
  logic [BCW-1:0]    r_burst_cnt;

  // Issue stage towards the shared unit.
  logic              r_act_in_valid;
  logic [DATA_W-1:0] r_act_in_data;

  // Tag pipeline, one entry per cycle of unit latency.
  logic              r_tag_valid [LAT];
  logic [IDW-1:0]    r_tag_id    [LAT];

  // Response / error side.
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_err;
  logic [GCW-1:0]     r_guard;

  logic [DATA_W-1:0]  w_slice [NUM_REQ];
  logic               w_grant_found;
  logic [IDW-1:0]     w_grant_id;
  logic [IDW-1:0]     w_cand;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic               w_tail_valid;
  logic [IDW-1:0]     w_tail_id;
  logic [NUM_REQ-1:0] w_rsp_onehot;
  logic               w_busy;

  genvar gi;

  // Unpack the flat request bus into per-channel slices.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slice[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Grant selection: keep the owner while its burst budget lasts, otherwise
  // search circularly starting after the owner, so the owner comes last.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = r_owner;
    w_cand        = r_owner;
    if (r_state == ST_HOLD && req_valid[r_owner] && r_burst_cnt < BCW'(MAX_BURST)) begin
      w_grant_found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = IDW'((int'(r_owner) + k) % NUM_REQ);
        if (!w_grant_found && req_valid[w_cand]) begin
          w_grant_found = 1'b1;
          w_grant_id    = w_cand;
        end
      end
    end
  end

  // One-hot ready, held low during reset so nothing is accepted then.
  always_comb begin
    w_ready = '0;
    if (!rst && w_grant_found) begin
      w_ready[w_grant_id] = 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign w_accept  = |(req_valid & w_ready);

  // Owner / burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= IDW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      r_state <= ST_HOLD;
      r_owner <= w_grant_id;
      if (r_state == ST_HOLD && w_grant_id == r_owner && r_burst_cnt < BCW'(MAX_BURST)) begin
        r_burst_cnt <= r_burst_cnt + BCW'(1);
      end else begin
        r_burst_cnt <= BCW'(1);
      end
    end else begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
    end
  end

  // Register the accepted beat towards the shared unit; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_in_valid <= 1'b0;
      r_act_in_data  <= '0;
    end else begin
      r_act_in_valid <= w_accept;
      if (w_accept) begin
        r_act_in_data <= w_slice[w_grant_id];
      end
    end
  end

  // Tag pipeline: the head follows the issue register, the rest shift along.
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // Capture the tag of the beat being issued this cycle.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_tag_valid[gi] <= 1'b0;
            r_tag_id[gi]    <= '0;
          end else begin
            r_tag_valid[gi] <= r_act_in_valid;
            r_tag_id[gi]    <= r_owner;
          end
        end
      end else begin : g_body
        // Advance the tag one stage per cycle, matching the unit latency.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_tag_valid[gi] <= 1'b0;
            r_tag_id[gi]    <= '0;
          end else begin
            r_tag_valid[gi] <= r_tag_valid[gi-1];
            r_tag_id[gi]    <= r_tag_id[gi-1];
          end
        end
      end
    end
  endgenerate

  assign w_tail_valid = r_tag_valid[LAT-1];
  assign w_tail_id    = r_tag_id[LAT-1];

  // Decode the matched result into a per-channel valid.
  always_comb begin
    w_rsp_onehot = '0;
    if (act_out_valid && w_tail_valid) begin
      w_rsp_onehot[w_tail_id] = 1'b1;
    end
  end

  // Register the routed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_onehot;
      if (act_out_valid && w_tail_valid) begin
        r_rsp_data <= act_out_data;
      end
    end
  end

  // Post-reset guard masks stale results of beats issued before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_guard <= GCW'(LAT + 1);
    end else if (r_guard != '0) begin
      r_guard <= r_guard - GCW'(1);
    end
  end

  // Sticky error on any tag/result mismatch at the pipeline tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((act_out_valid && !w_tail_valid && r_guard == '0) ||
                 (w_tail_valid && !act_out_valid)) begin
      r_err <= 1'b1;
    end
  end

  // Busy while the issue register or any tag stage holds a beat.
  always_comb begin
    w_busy = r_act_in_valid;
    for (int k = 0; k < LAT; k++) begin
      w_busy = w_busy | r_tag_valid[k];
    end
  end

  assign act_in_valid = r_act_in_valid;
  assign act_in_data  = r_act_in_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign busy         = w_busy;
  assign err          = r_err;

endmodule

// File: doc/selu_act_arbiter.md
# selu_act_arbiter

Round-robin arbiter that shares one pipelined int8 activation unit (the SELU LUT stage, fixed latency, no backpressure) between NUM_REQ requesting channels. It accepts one beat per cycle from the granted channel, forwards it to the shared unit, and tracks each in-flight beat with a channel tag. Results are routed back to the originating channel. It sits between the per-channel PE output streams and the single activation instance, and flags any result that arrives with no matching issued beat.

## Interface
- NUM_REQ, 4, number of requesting channels (2..8)
- DATA_W, 8, data width of requests and results
- LAT, 2, fixed latency of the shared unit: act_in_valid at cycle c gives act_out_valid at c+LAT
- MAX_BURST, 4, maximum consecutive beats granted to one channel while others wait (>=1)

- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-channel request valid
- req_data  in  NUM_REQ*DATA_W  per-channel signed data; channel i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot or zero, combinational grant
- act_in_valid  out  1  registered beat valid to the shared unit
- act_in_data  out  DATA_W  registered beat data to the shared unit
- act_out_valid  in  1  result valid from the shared unit
- act_out_data  in  DATA_W  result data from the shared unit
- rsp_valid  out  NUM_REQ  registered one-hot result valid per channel
- rsp_data  out  DATA_W  registered result, broadcast to all channels
- busy  out  1  high while any beat is in flight (tag pipeline non-empty)
- err  out  1  sticky; set on an act_out_valid with no matching tag; cleared only by rst

## Operation
- Arbiter states:
  - IDLE: no owner.
  - HOLD: owner, with burst_cnt counting beats accepted consecutively by the owner.
- Grant in HOLD: if req_valid[owner] and burst_cnt < MAX_BURST, the grant goes to the owner.
- Otherwise, the grant goes to the first asserted req_valid found by searching circularly from last_owner+1.
  - last_owner resets to NUM_REQ-1, so channel 0 has priority first.
  - The owner itself is searched last, so it is re-granted only if no other channel requests.
- A re-grant to the same channel after exhaustion resets burst_cnt to 1.
- The selected channel's req_ready is high; every other bit is 0; with no request all bits are 0.
- Accept = req_valid & req_ready.
- On accept: the owner becomes the granted channel, burst_cnt becomes 1 for a new owner or +1 for the same owner, and the state becomes HOLD.
- On a cycle with no accept: the state goes to IDLE and burst_cnt goes to 0.
- On an accepted beat, the next cycle has act_in_valid=1 and act_in_data equal to the granted slice. Otherwise act_in_valid=0 and act_in_data holds its value.
- Tag pipeline: LAT stages of {valid, channel id}, loaded from act_in_valid and the owner id, advancing every cycle.
- At the pipeline tail:
  - If act_out_valid=1 and tail valid=1, then next cycle rsp_valid[tail id]=1 and rsp_data=act_out_data.
  - If act_out_valid=1 and tail valid=0, set err unless the post-reset guard is active.
  - If tail valid=1 and act_out_valid=0, set err; no response is produced.
- Post-reset guard: a counter loaded to LAT+1 by rst, decrementing to 0. While it is non-zero, unmatched act_out_valid is ignored, because those are stale results from beats issued before reset.
- busy = OR of the tag-pipeline valid bits and act_in_valid.

## Timing
- Reset values: req_ready=0 (combinational, forced low while rst=1), act_in_valid=0, act_in_data=0, rsp_valid=0, rsp_data=0, busy=0, err=0, state IDLE, burst_cnt=0, all tags invalid.
- Latency: a beat accepted on the edge ending cycle t gives act_in_valid in cycle t+1 and act_out_valid in cycle t+1+LAT. rsp_valid is high in cycle t+2+LAT, which is cycle t+4 at default.
- Throughput is 1 beat/cycle with any mix of channels; there is no stall, because the shared unit and the responders always accept.
- rst asserted mid-operation: in-flight beats are discarded, no rsp is produced for them, and err is not set by their late results.
- Simultaneous accept and response in the same cycle are independent; both occur.

## Test plan
- Single beat: ch2 sends 0x10 with the other channels idle.
  - req_ready=4'b0100 in the same cycle.
  - act_in_valid in cycle +1 with data 0x10.
  - Emulated unit returns 0x21; rsp_valid=4'b0100 with rsp_data=0x21 at +4.
- Burst cap: ch0 and ch1 hold req_valid continuously.
  - Grants are ch0×4, ch1×4, ch0×4, and so on.
  - Result routing matches issue order exactly.
- Round-robin rotation: all 4 channels are valid, with MAX_BURST=1.
  - Grant order is 0,1,2,3,0 on consecutive cycles.
  - The rsp_valid one-hot sequence follows the same order, 4 cycles later.
- Error detect:
  - Inject act_out_valid with an empty pipeline, after the guard has expired: err=1 next cycle and stays 1.
  - Drop an expected act_out_valid: err=1.
- Reset mid-flight: issue 3 beats, assert rst for 1 cycle, then let the unit emit the 3 stale results.
  - No rsp_valid, err=0, busy=0 after reset.
  - Next accepted request is granted to ch0 first.
- Back-to-back stream: ch3 streams 0x00..0xFF continuously.
  - 256 consecutive responses with no gaps, in order, on ch3 only.
  - busy falls LAT+1 cycles after the last accept.
